spi_reg_bridge: RTL

Byte-level register-access bridge that sits directly downstream of `spi_slave` on its parallel side. It consumes received bytes (`data_rx`/`rx_valid`/`rx_read`) and feeds transmit bytes (`data_tx`/`tx_valid`/`tx_ready`). It decodes a command/address/data protocol and maintains an internal register file readable and writable by the SPI master. Core logic sees the register contents through a read port and a per-write strobe.

---
 rtl/spi_reg_bridge.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: command/address/data protocol over spi_slave bytes onto a register file.
// Define SPI_REG_BRIDGE_AUTOINC_EN to advance the address after every data or dummy byte.
module spi_reg_bridge #(
    parameter int         NUM_REGS = 16,
    parameter logic [7:0] ID_BYTE  = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_rx,
    input  logic       rx_valid,
    output logic       rx_read,
    output logic [7:0] data_tx,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       cs_n,
    input  logic [6:0] usr_addr,
    output logic [7:0] usr_rdata,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       addr_err
);
    localparam logic [7:0] NR   = 8'(NUM_REGS);
    localparam logic [6:0] LAST = 7'(NUM_REGS - 1);
    typedef enum logic [2:0] {ID_LOAD, CMD, WRITE, RD_LOAD, RD_WAIT} state_t;
    state_t     state, state_n;
    logic       cs_meta, cs_sync, cs_prev, frame_start, frame_end, accept;
    logic [6:0] addr, addr_n, adv_addr, rd_a;
    logic       tx_valid_n, wr_n, err_n, rd_oor, wr_ok;
    logic [7:0] data_tx_n, rd_byte, rd_raw;
    logic [7:0] regs [NUM_REGS];
    assign frame_start = cs_prev & ~cs_sync;
    assign frame_end   = ~cs_prev & cs_sync;
    assign accept      = rx_valid & ~rx_read;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    assign adv_addr = (addr == LAST) ? 7'd0 : addr + 7'd1;
`else
    assign adv_addr = addr;
`endif
    // Read data is prepared for the address the FSM is about to move to.
    assign rd_a    = (state == CMD) ? data_rx[6:0] : adv_addr;
    assign rd_oor  = {1'b0, rd_a} >= NR;
    assign rd_byte = rd_oor ? 8'hFF : rd_raw;
    assign wr_ok   = {1'b0, addr} < NR;
    always_comb begin
        usr_rdata = 8'h00;
        rd_raw    = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (usr_addr == 7'(i)) usr_rdata = regs[i];
            if (rd_a == 7'(i)) rd_raw = regs[i];
        end
    end
    always_comb begin
        state_n    = state;
        addr_n     = addr;
        tx_valid_n = tx_valid;
        data_tx_n  = data_tx;
        wr_n       = 1'b0;
        err_n      = addr_err & ~frame_start;
        case (state)
            ID_LOAD: begin
                if (!tx_valid) begin
                    tx_valid_n = 1'b1;
                    data_tx_n  = ID_BYTE;
                end else if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    state_n    = CMD;
                end
            end
            CMD: if (accept) begin
                addr_n  = data_rx[6:0];
                state_n = data_rx[7] ? RD_LOAD : WRITE;
                if (data_rx[7]) begin
                    tx_valid_n = 1'b1;
                    data_tx_n  = rd_byte;
                    err_n      = err_n | rd_oor;
                end
            end
            WRITE: if (accept) begin
                wr_n   = wr_ok;
                err_n  = err_n | ~wr_ok;
                addr_n = adv_addr;
            end
            RD_LOAD: if (tx_valid && tx_ready) begin
                tx_valid_n = 1'b0;
                state_n    = RD_WAIT;
            end
            RD_WAIT: if (accept) begin
                addr_n     = adv_addr;
                state_n    = RD_LOAD;
                tx_valid_n = 1'b1;
                data_tx_n  = rd_byte;
                err_n      = err_n | rd_oor;
            end
            default: state_n = ID_LOAD;
        endcase
        // Frame end overrides the handshake but never the byte just accepted.
        if (frame_end) begin
            state_n    = ID_LOAD;
            tx_valid_n = 1'b0;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
            state     <= ID_LOAD;
            addr      <= 7'd0;
            rx_read   <= 1'b0;
            tx_valid  <= 1'b0;
            data_tx   <= ID_BYTE;
            wr_strobe <= 1'b0;
            wr_addr   <= 7'd0;
            wr_data   <= 8'h00;
            addr_err  <= 1'b0;
        end else begin
            cs_meta   <= cs_n;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
            state     <= state_n;
            addr      <= addr_n;
            rx_read   <= accept;
            tx_valid  <= tx_valid_n;
            data_tx   <= data_tx_n;
            wr_strobe <= wr_n;
            addr_err  <= err_n;
            if (wr_n) begin
                wr_addr <= addr;
                wr_data <= data_rx;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else if (wr_strobe) begin
            for (int i = 0; i < NUM_REGS; i++) if (wr_addr == 7'(i)) regs[i] <= wr_data;
        end
    end
endmodule
